collatz_orbit_engine: RTL and testbench



---
 rtl/collatz_orbit_engine_if.sv | 34 +++
 rtl/collatz_orbit_engine.sv | 180 ++++++++++++++++++
 tb/tb_collatz_orbit_engine.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/collatz_orbit_engine_if.sv
// collatz_orbit_engine_if
// Host-side bus of the Collatz orbit engine: word-wise load of the start
// value, run control and registered word-wise readout.
//   wr_en/wr_addr/wr_data : write one DW-bit word of the iterator
//   start                 : level, begins a run when the engine is idle/done
//   rd_sel/rd_addr        : select register (0 len, 1 path, 2 status, 3 iter)
//                           and word index
//   rd_data               : registered readout word
//   busy/done             : run in progress / results held
// The master modport is the host side; the slave modport is the engine side.
interface collatz_orbit_engine_if #(
  parameter int AW = 5,
  parameter int DW = 8
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          start;
  logic [1:0]    rd_sel;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          done;

  modport master (
    output wr_en, wr_addr, wr_data, start, rd_sel, rd_addr,
    input  rd_data, busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, rd_sel, rd_addr,
    output rd_data, busy, done
  );
endinterface

// File: rtl/collatz_orbit_engine.sv
// collatz_orbit_engine
// Steps the Collatz orbit of a BITS-wide start value one iteration per clock
// until it reaches 1, tracking orbit length, the largest iterate seen and
// overflow / saturation / zero-start status for word-wise readout.
// Ports:
//   clk   : clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : collatz_orbit_engine_if.slave (load, start, readout, busy, done)
// Optional feature macro COLLATZ_SHORTCUT_EN: an odd step yields (3n+1)/2 in
// one cycle and adds 2 to the orbit length; results match the default build,
// only the cycle count shrinks.
module collatz_orbit_engine #(
  parameter int BITS      = 144,
  parameter int OLEN_BITS = 16,
  parameter int DW        = 8,
  parameter int AW        = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  collatz_orbit_engine_if.slave  bus
);

  localparam int NW = BITS / DW;
  localparam int PW = (1 << AW) * DW;
  localparam logic [OLEN_BITS:0] INC_ONE = (OLEN_BITS + 1)'(1);
`ifdef COLLATZ_SHORTCUT_EN
  localparam logic [OLEN_BITS:0] INC_ODD = (OLEN_BITS + 1)'(2);
`else
  localparam logic [OLEN_BITS:0] INC_ODD = (OLEN_BITS + 1)'(1);
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state, state_next;
  logic [BITS-1:0]      iter, iter_next;
  logic [BITS-1:0]      path_rec, path_next;
  logic [OLEN_BITS-1:0] orbit_len, len_next;
  logic                 ovf, ovf_next;
  logic                 sat, sat_next;
  logic                 zero_err, zero_next;
  logic [DW-1:0]        rd_q;

  // 3n+1 is formed two bits wider than the iterator so overflow is visible
  logic [BITS+1:0]      t;
  logic                 t_ovf;
  logic [BITS-1:0]      half;
  logic [BITS-1:0]      odd_val;
  logic [BITS-1:0]      step_val;
  logic [BITS-1:0]      peak;
  logic [OLEN_BITS:0]   len_sum;

  assign t     = {2'b00, iter} + {1'b0, iter, 1'b0} + {{(BITS + 1){1'b0}}, 1'b1};
  assign t_ovf = |t[BITS+1:BITS];
  assign half  = {1'b0, iter[BITS-1:1]};

`ifdef COLLATZ_SHORTCUT_EN
  assign odd_val = {1'b0, t[BITS-1:1]};
`else
  assign odd_val = t[BITS-1:0];
`endif

  // The path record always sees the unhalved 3n+1, so it does not depend on
  // whether the shortcut step is built in.
  assign step_val = iter[0] ? odd_val : half;
  assign peak     = iter[0] ? t[BITS-1:0] : half;
  assign len_sum  = {1'b0, orbit_len} + (iter[0] ? INC_ODD : INC_ONE);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      iter      <= '0;
      path_rec  <= '0;
      orbit_len <= '0;
      ovf       <= 1'b0;
      sat       <= 1'b0;
      zero_err  <= 1'b0;
    end else begin
      state     <= state_next;
      iter      <= iter_next;
      path_rec  <= path_next;
      orbit_len <= len_next;
      ovf       <= ovf_next;
      sat       <= sat_next;
      zero_err  <= zero_next;
    end
  end

  // Next-state logic: loading and starting only outside RUN, a write always
  // wins over start, and a run ends on reaching 1, on 3n+1 overflow (step not
  // taken) or on orbit-length saturation (step taken, length clamped).
  always_comb begin
    state_next = state;
    iter_next  = iter;
    path_next  = path_rec;
    len_next   = orbit_len;
    ovf_next   = ovf;
    sat_next   = sat;
    zero_next  = zero_err;

    case (state)
      IDLE, DONE: begin
        if (bus.wr_en) begin
          if (int'(bus.wr_addr) < NW) begin
            iter_next[bus.wr_addr*DW +: DW] = bus.wr_data;
          end
          ovf_next   = 1'b0;
          sat_next   = 1'b0;
          zero_next  = 1'b0;
          state_next = IDLE;
        end else if (bus.start) begin
          len_next  = '0;
          path_next = iter;
          ovf_next  = 1'b0;
          sat_next  = 1'b0;
          zero_next = 1'b0;
          if (iter == '0) begin
            zero_next  = 1'b1;
            state_next = DONE;
          end else if (iter == {{(BITS - 1){1'b0}}, 1'b1}) begin
            state_next = DONE;
          end else begin
            state_next = RUN;
          end
        end
      end

      RUN: begin
        if (iter[0] && t_ovf) begin
          ovf_next   = 1'b1;
          state_next = DONE;
        end else begin
          iter_next = step_val;
          if (peak > path_rec) begin
            path_next = peak;
          end
          if (len_sum[OLEN_BITS]) begin
            len_next   = '1;
            sat_next   = 1'b1;
            state_next = DONE;
          end else begin
            len_next = len_sum[OLEN_BITS-1:0];
            if (step_val == {{(BITS - 1){1'b0}}, 1'b1}) begin
              state_next = DONE;
            end
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // Readout source, zero-extended so out-of-range word indices read 0
  logic [PW-1:0] rd_src;

  always_comb begin
    rd_src = '0;
    case (bus.rd_sel)
      2'd0:    rd_src = PW'(orbit_len);
      2'd1:    rd_src = PW'(path_rec);
      2'd2:    rd_src = PW'({zero_err, sat, ovf, (state == DONE)});
      default: rd_src = PW'(iter);
    endcase
  end

  // Registered readout word, refreshed every cycle in every state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_src[bus.rd_addr*DW +: DW];
    end
  end

  assign bus.rd_data = rd_q;
  assign bus.busy    = (state == RUN);
  assign bus.done    = (state == DONE);

endmodule

// File: tb/tb_collatz_orbit_engine.sv
// tb_collatz_orbit_engine
// Directed bench for collatz_orbit_engine: a default instance plus an
// OLEN_BITS=4 instance fed the same host stimulus. Expected values are hand
// computed from the Collatz orbits of 27, 6, 0, 1 and 2^144-1.
module tb_collatz_orbit_engine;
  localparam int BITS = 144;
  localparam int DW   = 8;
  localparam int AW   = 5;
  localparam int NW   = BITS / DW;
`ifdef COLLATZ_SHORTCUT_EN
  localparam int CYC27 = 70;
  localparam int CYC6  = 6;
`else
  localparam int CYC27 = 111;
  localparam int CYC6  = 8;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  collatz_orbit_engine_if #(.AW(AW), .DW(DW)) bus ();
  collatz_orbit_engine_if #(.AW(AW), .DW(DW)) bus4 ();

  // The small-counter instance mirrors every host input of the main one
  assign bus4.wr_en   = bus.wr_en;
  assign bus4.wr_addr = bus.wr_addr;
  assign bus4.wr_data = bus.wr_data;
  assign bus4.start   = bus.start;
  assign bus4.rd_sel  = bus.rd_sel;
  assign bus4.rd_addr = bus.rd_addr;

  collatz_orbit_engine #(.BITS(BITS), .OLEN_BITS(16), .DW(DW), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  collatz_orbit_engine #(.BITS(BITS), .OLEN_BITS(4), .DW(DW), .AW(AW)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic writeWord(input int addr, input logic [DW-1:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = AW'(addr);
    bus.wr_data = data;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic loadValue(input logic [BITS-1:0] value);
    for (int i = 0; i < NW; i++) begin
      writeWord(i, value[i*DW +: DW]);
    end
  endtask

  task automatic readWord(input logic [1:0] sel, input int addr,
                          output logic [DW-1:0] data);
    bus.rd_sel  = sel;
    bus.rd_addr = AW'(addr);
    @(negedge clk);
    data = bus.rd_data;
  endtask

  task automatic applyStimulus();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Counts cycles spent busy, bounded so a stuck engine still ends the run
  task automatic waitDone(output int cycles);
    cycles = 0;
    while (bus.busy && cycles < 2000) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("done_reached", 32'(bus.done), 32'd1);
  endtask

  logic [DW-1:0] d;
  int            cyc;

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.start   = 1'b0;
    bus.rd_sel  = 2'd2;
    bus.rd_addr = '0;
    rst_n       = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_done", 32'(bus.done), 32'd0);
    checkOutput("reset_rd_data", 32'(bus.rd_data), 32'd0);
    rst_n = 1'b1;
    readWord(2'd2, 0, d);
    checkOutput("reset_status", 32'(d), 32'h00);
    readWord(2'd3, 0, d);
    checkOutput("reset_iter", 32'(d), 32'h00);

    // Zero start value: immediate done with zero_err
    applyStimulus();
    checkOutput("zero_done", 32'(bus.done), 32'd1);
    checkOutput("zero_busy", 32'(bus.busy), 32'd0);
    readWord(2'd2, 0, d);
    checkOutput("zero_status", 32'(d), 32'h09);

    // Start value 1: write in DONE returns to idle, then immediate done
    writeWord(0, 8'h01);
    checkOutput("write_clears_done", 32'(bus.done), 32'd0);
    applyStimulus();
    checkOutput("one_busy", 32'(bus.busy), 32'd0);
    checkOutput("one_done", 32'(bus.done), 32'd1);
    readWord(2'd0, 0, d);
    checkOutput("one_len", 32'(d), 32'h00);
    readWord(2'd2, 0, d);
    checkOutput("one_status", 32'(d), 32'h01);

    // Start value 27: full orbit, also saturates the 4-bit instance
    writeWord(0, 8'h1B);
    applyStimulus();
    checkOutput("run27_busy", 32'(bus.busy), 32'd1);
    waitDone(cyc);
    checkOutput("run27_cycles", 32'(cyc), 32'(CYC27));
    readWord(2'd0, 0, d);
    checkOutput("run27_len0", 32'(d), 32'h6F);
    checkOutput("sat4_len0", 32'(bus4.rd_data), 32'h0F);
    readWord(2'd0, 1, d);
    checkOutput("run27_len1", 32'(d), 32'h00);
    readWord(2'd1, 0, d);
    checkOutput("run27_path0", 32'(d), 32'h10);
    checkOutput("sat4_path0", 32'(bus4.rd_data), 32'hE4);
    readWord(2'd1, 1, d);
    checkOutput("run27_path1", 32'(d), 32'h24);
    readWord(2'd1, 2, d);
    checkOutput("run27_path2", 32'(d), 32'h00);
    readWord(2'd2, 0, d);
    checkOutput("run27_status", 32'(d), 32'h01);
    checkOutput("sat4_status", 32'(bus4.rd_data), 32'h05);
    readWord(2'd3, 0, d);
    checkOutput("run27_iter0", 32'(d), 32'h01);
    readWord(2'd0, 5, d);
    checkOutput("len_out_of_range", 32'(d), 32'h00);
    readWord(2'd3, 31, d);
    checkOutput("iter_out_of_range", 32'(d), 32'h00);

    // All-ones start value: first odd step overflows
    loadValue('1);
    applyStimulus();
    waitDone(cyc);
    checkOutput("ovf_cycles", 32'(cyc), 32'd1);
    readWord(2'd2, 0, d);
    checkOutput("ovf_status", 32'(d), 32'h03);
    readWord(2'd0, 0, d);
    checkOutput("ovf_len", 32'(d), 32'h00);
    readWord(2'd3, 0, d);
    checkOutput("ovf_iter0", 32'(d), 32'hFF);
    readWord(2'd3, NW - 1, d);
    checkOutput("ovf_iter_top", 32'(d), 32'hFF);
    readWord(2'd1, NW - 1, d);
    checkOutput("ovf_path_top", 32'(d), 32'hFF);

    // Mid-run: write and start are ignored while the iterator evolves
    loadValue(BITS'(27));
    applyStimulus();
    bus.rd_sel  = 2'd3;
    bus.rd_addr = '0;
    bus.wr_en   = 1'b1;
    bus.wr_addr = '0;
    bus.wr_data = 8'h55;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.start = 1'b0;
    checkOutput("midrun_iter_a", 32'(bus.rd_data), 32'h1B);
    checkOutput("midrun_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    checkOutput("midrun_iter_b", 32'(bus.rd_data), 32'h52);
    @(negedge clk);
    checkOutput("midrun_iter_c", 32'(bus.rd_data), 32'h29);
    repeat (7) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("async_reset_done", 32'(bus.done), 32'd0);
    checkOutput("async_reset_rd", 32'(bus.rd_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    readWord(2'd3, 0, d);
    checkOutput("after_reset_iter", 32'(d), 32'h00);

    // Same-cycle write and start in DONE: write wins, no run
    writeWord(0, 8'h01);
    applyStimulus();
    checkOutput("pre_combo_done", 32'(bus.done), 32'd1);
    bus.start = 1'b1;
    writeWord(0, 8'h06);
    bus.start = 1'b0;
    checkOutput("combo_done", 32'(bus.done), 32'd0);
    checkOutput("combo_busy", 32'(bus.busy), 32'd0);
    readWord(2'd3, 0, d);
    checkOutput("combo_iter", 32'(d), 32'h06);
    applyStimulus();
    waitDone(cyc);
    checkOutput("run6_cycles", 32'(cyc), 32'(CYC6));
    readWord(2'd0, 0, d);
    checkOutput("run6_len", 32'(d), 32'h08);
    readWord(2'd1, 0, d);
    checkOutput("run6_path", 32'(d), 32'h10);
    readWord(2'd2, 0, d);
    checkOutput("run6_status", 32'(d), 32'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
